// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath constants and types
// Purpose: common widths, round-count and FSM state type for the AES-256 round logic.
// Contents: AES_NR, AES_BLK_W, round_idx_t, state_t.
package aes_pkg;

  localparam int AES_NR    = 14;
  localparam int AES_BLK_W = 128;

  typedef logic [3:0] round_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/round_key_table.sv
// rtl/round_key_table.sv - (NR+1) x 128 round-key register file
// Purpose: holds the round keys loaded by the key schedule; not reset.
// Ports:
//   clk      - system clock
//   we_i     - write strobe (already gated by the caller's busy state)
//   waddr_i  - write index; writes above NR are dropped
//   wdata_i  - key data
//   raddr_i  - read index, combinational read
//   rdata_o  - key at raddr_i
module round_key_table
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [3:0]           waddr_i,
  input  logic [AES_BLK_W-1:0] wdata_i,
  input  logic [3:0]           raddr_i,
  output logic [AES_BLK_W-1:0] rdata_o
);

  localparam round_idx_t MAX_IDX = round_idx_t'(NR);

  logic [AES_BLK_W-1:0] mem_q [0:NR];
  logic                 in_range;

  assign in_range = (waddr_i <= MAX_IDX);

  always_ff @(posedge clk) begin
    if (we_i && in_range) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - registered AddRoundKey stage with round-key table
// Purpose: XORs each accepted 128-bit state with key[round] and registers the
//          result with its round index; one block is NR+1 accepts long.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   key_we_i/key_addr_i/key_data_i   - round-key table load (idle only)
//   start_i                          - begin a block at round 0 (idle only)
//   state_valid_i/state_i/state_ready_o - input handshake
//   state_valid_o/state_o/state_ready_i - output handshake
//   round_o, last_o                  - round tag of state_o, final-round flag
//   busy_o                           - block in progress
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_we_i,
  input  logic [3:0]           key_addr_i,
  input  logic [AES_BLK_W-1:0] key_data_i,
  input  logic                 start_i,
  input  logic                 state_valid_i,
  input  logic [AES_BLK_W-1:0] state_i,
  output logic                 state_ready_o,
  output logic                 state_valid_o,
  output logic [AES_BLK_W-1:0] state_o,
  input  logic                 state_ready_i,
  output logic [3:0]           round_o,
  output logic                 last_o,
  output logic                 busy_o
);

  localparam round_idx_t LAST_RND = round_idx_t'(NR);

  state_t               state_q, state_d;
  round_idx_t           rnd_q, rnd_d;
  logic                 valid_q, valid_d;
  logic [AES_BLK_W-1:0] data_q, data_d;
  round_idx_t           round_q, round_d;
  logic                 last_q, last_d;

  logic [AES_BLK_W-1:0] rkey;
  logic                 busy;
  logic                 ready;
  logic                 accept;
  logic                 at_last;

  assign busy    = (state_q == RUN);
  // Single-entry output register: a slot frees up when it is empty or being drained.
  assign ready   = busy && (!valid_q || state_ready_i);
  assign accept  = state_valid_i && ready;
  assign at_last = (rnd_q == LAST_RND);

  // Writes are blocked during a block so every round sees a stable key set.
  round_key_table #(.NR(NR)) u_key_table (
    .clk     (clk),
    .we_i    (key_we_i && !busy),
    .waddr_i (key_addr_i),
    .wdata_i (key_data_i),
    .raddr_i (rnd_q),
    .rdata_o (rkey)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    data_d  = data_q;
    round_d = round_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          rnd_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          // The final round ends the block instead of letting the counter pass NR.
          if (at_last) begin
            state_d = IDLE;
            rnd_d   = '0;
          end else begin
            rnd_d = round_idx_t'(rnd_q + 4'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      valid_d = 1'b1;
      data_d  = state_i ^ rkey;
      round_d = rnd_q;
      last_d  = at_last;
    end else if (state_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      round_q <= round_d;
      last_q  <= last_d;
    end
  end

  assign state_ready_o = ready;
  assign state_valid_o = valid_q;
  assign state_o       = data_q;
  assign round_o       = round_q;
  assign last_o        = last_q;
  assign busy_o        = busy;

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - self-checking bench for add_round_key_stage
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_we = 1'b0;
  logic [3:0]   key_addr = '0;
  logic [127:0] key_data = '0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         out_ready = 1'b0;
  logic         state_ready_o;
  logic         state_valid_o;
  logic [127:0] state_o;
  logic [3:0]   round_o;
  logic         last_o;
  logic         busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_round_key_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_we_i      (key_we),
    .key_addr_i    (key_addr),
    .key_data_i    (key_data),
    .start_i       (start),
    .state_valid_i (in_valid),
    .state_i       (in_state),
    .state_ready_o (state_ready_o),
    .state_valid_o (state_valid_o),
    .state_o       (state_o),
    .state_ready_i (out_ready),
    .round_o       (round_o),
    .last_o        (last_o),
    .busy_o        (busy_o)
  );

  // Reference model: key table contents plus the expected output register.
  logic [127:0] tkey [0:14];
  bit           m_run;
  int           m_rnd;
  bit           m_valid;
  logic [127:0] m_data;
  int           m_round;
  bit           m_last;
  bit           exp_ready;
  logic         obs_ready;

  function automatic logic [127:0] bytes16(input logic [7:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  // One clock: drive inputs, sample ready before the edge, advance the model at the edge.
  task automatic tick(input logic v, input logic [127:0] s, input logic rdy,
                      input logic st, input logic we, input logic [3:0] a,
                      input logic [127:0] kd);
    bit run_prev;
    bit acc;
    in_valid = v; in_state = s; out_ready = rdy; start = st;
    key_we = we; key_addr = a; key_data = kd;
    #1;
    obs_ready = state_ready_o;
    exp_ready = m_run && (!m_valid || rdy);
    acc = m_run && v && exp_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_rnd = 0; m_valid = 0; m_data = '0; m_round = 0; m_last = 0;
    end else begin
      run_prev = m_run;
      if (acc) begin
        m_data = s ^ tkey[m_rnd]; m_round = m_rnd; m_last = (m_rnd == 14); m_valid = 1;
        if (m_rnd == 14) begin m_run = 0; m_rnd = 0; end
        else m_rnd = m_rnd + 1;
      end else if (rdy) begin
        m_valid = 0;
      end
      if (!run_prev && we && a <= 14) tkey[a] = kd;
      if (!run_prev && st) begin m_run = 1; m_rnd = 0; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(0, '0, 0, 0, 0, 4'd0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", state_valid_o); end
    checks++; if (state_o !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", state_o); end
    checks++; if (round_o !== 4'd0 || last_o !== 1'b0) begin errors++; $display("FAIL reset_round_last: got %0d/%b want 0/0", round_o, last_o); end
    checks++; if (busy_o !== 1'b0 || state_ready_o !== 1'b0) begin errors++; $display("FAIL reset_busy_ready: got %b/%b want 0/0", busy_o, state_ready_o); end
  endtask

  task automatic test_single_round();
    do_reset();
    tick(0, '0, 1, 0, 1, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL start_cycle_ready: got %b want 0", obs_ready); end
    tick(1, 128'h00112233445566778899aabbccddeeff, 1, 0, 0, 4'd0, '0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b want 1", obs_ready); end
    checks++; if (state_valid_o !== 1'b1 || state_o !== 128'h00102030405060708090a0b0c0d0e0f0) begin
      errors++; $display("FAIL single_round_state: got v=%b %h want v=1 00102030405060708090a0b0c0d0e0f0", state_valid_o, state_o); end
    checks++; if (round_o !== 4'd0 || last_o !== 1'b0) begin errors++; $display("FAIL single_round_tag: got %0d/%b want 0/0", round_o, last_o); end
  endtask

  task automatic test_full_block();
    do_reset();
    for (int r = 0; r < 15; r++) tick(0, '0, 1, 0, 1, 4'(r), bytes16(8'(r)));
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    for (int r = 0; r < 15; r++) begin
      tick(1, {128{1'b1}}, 1, 0, 0, 4'd0, '0);
      checks++; if (obs_ready !== 1'b1 || state_valid_o !== 1'b1 || state_o !== bytes16(~8'(r))) begin
        errors++; $display("FAIL full_block_data r=%0d: got rdy=%b v=%b %h want 1 1 %h", r, obs_ready, state_valid_o, state_o, bytes16(~8'(r))); end
      checks++; if (round_o !== 4'(r) || last_o !== (r == 14)) begin
        errors++; $display("FAIL full_block_tag r=%0d: got %0d/%b want %0d/%b", r, round_o, last_o, r, (r == 14)); end
      checks++; if (busy_o !== (r != 14)) begin errors++; $display("FAIL full_block_busy r=%0d: got %b want %b", r, busy_o, (r != 14)); end
    end
    tick(1, {128{1'b1}}, 1, 0, 0, 4'd0, '0);
    checks++; if (obs_ready !== 1'b0 || state_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL full_block_after: got rdy=%b v=%b busy=%b want 0 0 0", obs_ready, state_valid_o, busy_o); end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    do_reset();
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    for (int r = 0; r < 3; r++) tick(1, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 4'd0, '0);
    held = state_o;
    checks++; if (round_o !== 4'd2 || held !== m_data) begin errors++; $display("FAIL bp_round2: got %0d %h want 2 %h", round_o, held, m_data); end
    for (int i = 0; i < 3; i++) begin
      tick(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 4'd0, '0);
      checks++; if (obs_ready !== 1'b0 || state_o !== held || round_o !== 4'd2 || state_valid_o !== 1'b1) begin
        errors++; $display("FAIL bp_hold i=%0d: got rdy=%b v=%b r=%0d %h want 0 1 2 %h", i, obs_ready, state_valid_o, round_o, state_o, held); end
    end
    tick(1, 128'h0123456789abcdef0123456789abcdef, 1, 0, 0, 4'd0, '0);
    checks++; if (obs_ready !== 1'b1 || round_o !== 4'd3 || state_o !== (128'h0123456789abcdef0123456789abcdef ^ tkey[3])) begin
      errors++; $display("FAIL bp_resume: got rdy=%b r=%0d %h want 1 3 %h", obs_ready, round_o, state_o, 128'h0123456789abcdef0123456789abcdef ^ tkey[3]); end
  endtask

  task automatic test_key_guards();
    do_reset();
    tick(0, '0, 1, 0, 1, 4'd15, {128{1'b1}});
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    tick(0, '0, 1, 0, 1, 4'd5, {16{8'haa}});
    for (int r = 0; r < 6; r++) tick(1, 128'hcafef00d_00000000_12345678_9abcdef0, 1, 0, 0, 4'd0, '0);
    checks++; if (round_o !== 4'd5 || state_o !== (128'hcafef00d_00000000_12345678_9abcdef0 ^ bytes16(8'h05))) begin
      errors++; $display("FAIL key_guard_r5: got %0d %h want 5 %h", round_o, state_o, 128'hcafef00d_00000000_12345678_9abcdef0 ^ bytes16(8'h05)); end
  endtask

  task automatic test_mid_reset();
    logic [127:0] s;
    do_reset();
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    for (int r = 0; r < 8; r++) tick(1, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 4'd0, '0);
    checks++; if (round_o !== 4'd7) begin errors++; $display("FAIL mid_reset_pre: got %0d want 7", round_o); end
    rst_n = 1'b0;
    tick(1, '0, 0, 0, 0, 4'd0, '0);
    rst_n = 1'b1;
    checks++; if (state_valid_o !== 1'b0 || busy_o !== 1'b0 || round_o !== 4'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b busy=%b r=%0d want 0 0 0", state_valid_o, busy_o, round_o); end
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    s = {$urandom, $urandom, $urandom, $urandom};
    tick(1, s, 1, 0, 0, 4'd0, '0);
    checks++; if (round_o !== 4'd0 || state_o !== (s ^ bytes16(8'h00))) begin
      errors++; $display("FAIL mid_reset_restart: got %0d %h want 0 %h", round_o, state_o, s); end
  endtask

  task automatic test_misuse();
    do_reset();
    tick(1, {128{1'b1}}, 1, 0, 0, 4'd0, '0);
    checks++; if (obs_ready !== 1'b0 || state_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL idle_valid: got rdy=%b v=%b busy=%b want 0 0 0", obs_ready, state_valid_o, busy_o); end
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    tick(1, '0, 1, 0, 0, 4'd0, '0);
    tick(1, '0, 1, 0, 0, 4'd0, '0);
    tick(0, '0, 1, 1, 0, 4'd0, '0);
    checks++; if (busy_o !== 1'b1 || state_valid_o !== 1'b0) begin errors++; $display("FAIL start_busy: got busy=%b v=%b want 1 0", busy_o, state_valid_o); end
    tick(1, 128'h5a5a, 1, 0, 0, 4'd0, '0);
    checks++; if (round_o !== 4'd2 || state_o !== (128'h5a5a ^ tkey[2])) begin
      errors++; $display("FAIL start_busy_round: got %0d %h want 2 %h", round_o, state_o, 128'h5a5a ^ tkey[2]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 20; i++) tick(0, '0, 1, 0, 1, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom});
      checks++; if (obs_ready !== exp_ready || state_valid_o !== m_valid || busy_o !== m_run) begin
        errors++; $display("FAIL rand_ctrl i=%0d: got rdy=%b v=%b busy=%b want %b %b %b", i, obs_ready, state_valid_o, busy_o, exp_ready, m_valid, m_run); end
      if (m_valid) begin
        checks++; if (state_o !== m_data || round_o !== 4'(m_round) || last_o !== m_last) begin
          errors++; $display("FAIL rand_data i=%0d: got %h r=%0d l=%b want %h r=%0d l=%b", i, state_o, round_o, last_o, m_data, m_round, m_last); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 15; i++) tkey[i] = 'x;
    m_run = 0; m_rnd = 0; m_valid = 0; m_data = '0; m_round = 0; m_last = 0;
    test_reset();
    test_single_round();
    test_full_block();
    test_backpressure();
    test_key_guards();
    test_mid_reset();
    test_misuse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_round_key_stage.md
# add_round_key_stage

Registered AddRoundKey stage for the AES-256-CTR datapath. It sits directly downstream of `mixcolumn`: each 128-bit state produced by the round logic is XORed with the round key for the current round, and the result is registered with its round index. The block holds the 15 AES-256 round keys in a local table loaded by the key schedule. Valid/ready handshakes on both sides let the round loop stall without losing data.

## Interface
Parameters:
- `NR`, default 14: number of AES rounds. Key table depth is `NR+1`.

Ports:
- `clk`  in  1  — system clock.
- `rst_n`  in  1  — reset; synchronous, active-low (already decided).
- `key_we_i`  in  1  — round-key table write strobe.
- `key_addr_i`  in  4  — round-key index, 0..NR.
- `key_data_i`  in  128  — round-key data.
- `start_i`  in  1  — starts a new block; the round counter goes to 0.
- `state_valid_i`  in  1  — input state valid.
- `state_i`  in  128  — state from `mixcolumn`, or from the initial-round path.
- `state_ready_o`  out  1  — stage accepts the input state.
- `state_valid_o`  out  1  — output state valid.
- `state_o`  out  128  — `state_i ^ key[round]`, registered.
- `state_ready_i`  in  1  — downstream accepts the output.
- `round_o`  out  4  — round index of the data on `state_o`.
- `last_o`  out  1  — `state_o` is the final round (`round_o == NR`).
- `busy_o`  out  1  — a block is in progress.

## Operation
The block has two states.

IDLE:
- `busy_o` = 0 and `state_ready_o` = 0.
- `start_i` moves the block to RUN and sets `rnd_q` = 0.
- A key write with `key_addr_i <= NR` writes the table. Writes with `key_addr_i > NR` are ignored.

RUN:
- `busy_o` = 1.
- `state_ready_o = !state_valid_o || state_ready_i`.
- Accept occurs when `state_valid_i && state_ready_o`. On accept:
  - `state_o <= state_i ^ key[rnd_q]`
  - `round_o <= rnd_q`
  - `last_o <= (rnd_q == NR)`
  - `state_valid_o <= 1`
  - `rnd_q` increments.
- An accept with `rnd_q == NR` returns the block to IDLE.
- `key_we_i` is ignored while busy, so the table is stable for the whole block.
- `start_i` is ignored while busy.

Output register:
- It is a single entry.
- `state_valid_o` clears when `state_ready_i` is high and there is no new accept in the same cycle.
- Data and the round tag hold stable while `state_valid_o && !state_ready_i`.

Width rules:
- `rnd_q` is 4 bits and never exceeds NR. It does not wrap: the final accept forces IDLE.
- The XOR is full 128-bit.
- Byte order is identical to `mixcolumn`: bits [127:120] are state byte 0.

## Timing
- Latency: 1 cycle from accept to `state_valid_o`.
- Throughput: 1 state per cycle when downstream is always ready.
- Reset values: `state_valid_o` = 0, `state_o` = 0, `round_o` = 0, `last_o` = 0, `busy_o` = 0, `state_ready_o` = 0, `rnd_q` = 0, state = IDLE. The key table is not reset.
- `start_i` and `key_we_i` in the same IDLE cycle: both take effect, and the write completes before round 0 can be accepted, which is the next cycle at the earliest.
- `state_ready_o` is 0 in the `start_i` cycle and first rises the cycle after.
- Final accept and `state_ready_i` in the same cycle: the previous output is consumed and the round-NR output loads; no bubble.
- `rst_n` low mid-block: the state returns to IDLE at the next edge; the in-flight output is dropped and `state_valid_o` = 0.
- Key table reads are combinational from registers. A single-port write with an asynchronous read is acceptable.

## Structure
- Shared package `aes_pkg`:
  - `AES_NR` = 14
  - `AES_BLK_W` = 128
  - `round_idx_t` (4-bit)
  - `state_t` enum {IDLE, RUN}
- One sub-module, `round_key_table`: `(NR+1)` × 128 register file with write enable, address-range check and combinational read. The round counter, FSM and output register stay in the top module.

## Test plan
1. Key load plus one round:
   - Stimulus: load key[0] = `000102030405060708090a0b0c0d0e0f`, pulse `start_i`, send `00112233445566778899aabbccddeeff`.
   - Response: `state_o` = `00102030405060708090a0b0c0d0e0f0`, `round_o` = 0, `last_o` = 0, one cycle after accept.
2. Full block:
   - Stimulus: key[r] = {16{r}} bytes, 15 back-to-back states of all-`ff`, `state_ready_i` held at 1.
   - Response:
     - output r = {16{~r}} bytes;
     - `round_o` counts 0..14;
     - `last_o` is high only on round 14;
     - `busy_o` falls the cycle after the 15th accept;
     - `state_ready_o` = 0 afterwards.
3. Backpressure:
   - Stimulus: hold `state_ready_i` = 0 for 3 cycles after round 2 is output.
   - Response: `state_o`/`round_o` stable, `state_ready_o` = 0, no round skipped; round 3 follows once ready.
4. Key-write guards:
   - Stimulus: write key[5] = all-`aa` while busy; write `key_addr_i` = 15 while idle.
   - Response: both ignored; a later round 5 still uses the original key[5].
5. Mid-block reset:
   - Stimulus: drive `rst_n` low during round 7.
   - Response: next cycle `state_valid_o` = 0, `busy_o` = 0, `round_o` = 0. A new `start_i` restarts at round 0 using the retained keys.
6. Misuse:
   - Stimulus: `state_valid_i` in IDLE; `start_i` while busy.
   - Response: no accept and no output; `rnd_q` unchanged.
